wallet_recharge: RTL and testbench
==================================

Name: wallet_recharge

Overview:
- Owns the customer's BCD balance (3 digits, 000–999) and drives the `bal` bus consumed by the billing block.
- Lets the user key in a top-up amount digit-by-digit with the centre/up/down button pulses, and commits it by BCD addition.
- Acts as the responder to billing's debit request: subtracts the charged amount and acknowledges.
- Sits between the button debouncers and billing, and supplies 4-nibble display data to the scan4 driver.

Parameters:
- INIT_BAL, 12'h196, BCD balance loaded at reset.
- TIMEOUT_CYC, 500000000, idle cycles in EDIT before the edit is abandoned (5 s at 100 MHz).
- HALF_SEC, 50000000, blink half-period for the selected digit.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-low reset
- on  in  1  global enable; when low, all state is frozen and no requests are accepted
- m_pos  in  1  one-cycle pulse, centre button
- u_pos  in  1  one-cycle pulse, up button
- d_pos  in  1  one-cycle pulse, down button
- debit_req  in  1  level; billing holds it high until debit_ack
- debit_amt  in  12  BCD amount to deduct; valid while debit_req is high
- bal  out  12  current BCD balance
- debit_ack  out  1  one-cycle pulse, debit completed
- debit_short  out  1  registered with debit_ack; balance was insufficient
- sat  out  1  one-cycle pulse, top-up clipped at 999
- editing  out  1  high while in EDIT
- disp  out  16  {n0,n3,n2,n1} nibbles for scan4; 4'd11 = blank

Behaviour:
- Reset (rst low, asynchronous) sets:
  - bal = INIT_BAL; state = IDLE; amt = 000; sel = 0
  - timer = 0; blink = 0; req_seen = 0
  - debit_ack = 0; debit_short = 0; sat = 0
  - disp = {4'd11, INIT_BAL}
- States: IDLE (0), EDIT (1), COMMIT (2), DEBIT (3).
- IDLE:
  - disp = {4'd11, bal}.
  - debit_req high and req_seen low → DEBIT.
  - Otherwise m_pos → EDIT with amt = 000, sel = 0 (ones digit), timer = 0.
  - debit_req has priority over m_pos in the same cycle.
- EDIT:
  - u_pos increments digit amt[sel] modulo 10 (9→0); d_pos decrements it (0→9). There is no carry into neighbouring digits.
  - u_pos and d_pos together: both are ignored, but the timer still resets.
  - m_pos with sel < 2 increments sel; m_pos with sel = 2 → COMMIT.
  - Any button pulse clears the timer. When timer reaches TIMEOUT_CYC-1 → IDLE, amt is discarded and bal is unchanged.
  - debit_req is not served in EDIT. It stays pending (no ack) until the next IDLE.
  - disp = {4'd11, amt}. The selected nibble shows 4'd11 while blink = 1; blink toggles every HALF_SEC cycles.
- COMMIT (1 cycle):
  - bal ← BCD(bal + amt), with per-digit decimal carry.
  - If the sum exceeds 999: bal = 12'h999 and sat is pulsed for 1 cycle.
  - Then → IDLE.
- DEBIT (1 cycle):
  - If bal ≥ debit_amt (BCD compare): bal ← BCD(bal − debit_amt), debit_short = 0.
  - Else: bal ← 000, debit_short = 1.
  - debit_ack is pulsed for 1 cycle, req_seen is set, then → IDLE.
- Handshake:
  - req_seen clears only when debit_req is sampled low, so exactly one debit is performed per request.
  - Latency from debit_req rising (in IDLE) to debit_ack is 2 cycles.
- Operands:
  - Non-BCD nibbles (>9) on debit_amt are treated as 9.
  - amt digits are always kept in 0–9.
- on low: every register holds its value and timers pause; outputs keep their last value, except that debit_ack and sat are forced to 0.
- rst asserted mid-EDIT or mid-DEBIT: the in-flight operation is abandoned and everything returns to its reset value.

Optional Feature:
- RECHARGE_BONUS_EN defined: in COMMIT, if amt ≥ 100 then bal ← BCD(bal + amt + 010). Saturation at 999 and the sat pulse still apply.
- Undefined: plain bal + amt, with no bonus logic synthesised.

Test Plan:
- Reset → bal = 196, disp = {B,1,9,6}, debit_ack = 0, editing = 0.
- In EDIT, enter amt = 025 (ones: 5 up pulses; m_pos; tens: 2 up pulses; m_pos; m_pos) from bal = 196 → bal = 221 one cycle after COMMIT, sat = 0.
- debit_req = 1 with debit_amt = 045 at bal = 221 → debit_ack 2 cycles later, bal = 176, debit_short = 0. Holding req high for 20 more cycles produces no second ack.
- debit_amt = 300 at bal = 176 → bal = 000, debit_short = 1, debit_ack = 1.
- Enter amt = 900 at bal = 176 → bal = 999, sat pulses 1 cycle. With RECHARGE_BONUS_EN, amt = 100 at bal = 000 → bal = 110.
- Enter EDIT, set ones digit to 7, then no input for TIMEOUT_CYC cycles → back to IDLE, bal unchanged. On the ones digit at 0, d_pos → digit = 9.

Source files
------------

// File: rtl/wallet_recharge_if.sv
// Billing <-> wallet debit channel: level request with amount, one-cycle ack/short, live balance.
interface wallet_recharge_if;
  logic        debit_req;
  logic [11:0] debit_amt;
  logic [11:0] bal;
  logic        debit_ack;
  logic        debit_short;

  modport master (
    output debit_req,
    output debit_amt,
    input  bal,
    input  debit_ack,
    input  debit_short
  );

  modport slave (
    input  debit_req,
    input  debit_amt,
    output bal,
    output debit_ack,
    output debit_short
  );
endinterface

// File: rtl/wallet_recharge.sv
// BCD wallet: button-driven top-up editor plus debit responder; ack 2 cycles after req in IDLE,
// req held off (no ack) while editing. Build option RECHARGE_BONUS_EN adds 010 to top-ups >= 100.
module wallet_recharge #(
  parameter logic [11:0] INIT_BAL    = 12'h196,
  parameter int unsigned TIMEOUT_CYC = 500000000,
  parameter int unsigned HALF_SEC    = 50000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               on,
  input  logic               m_pos,
  input  logic               u_pos,
  input  logic               d_pos,
  wallet_recharge_if.slave   bus,
  output logic               sat,
  output logic               editing,
  output logic [15:0]        disp
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int BW = $clog2(HALF_SEC + 1);
  localparam logic [3:0] BLANK = 4'd11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2,
    DEBIT  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [11:0]   bal_q, bal_d;
  logic [11:0]   amt_q, amt_d;
  logic [1:0]    sel_q, sel_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;
  logic          req_seen_q, req_seen_d;
  logic          ack_q, ack_d;
  logic          short_q, short_d;
  logic          sat_q, sat_d;

  function automatic logic [12:0] bcd_add(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] r;
    logic [4:0]  s;
    logic        c;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'd0, c};
      if (s > 5'd9) begin
        s = s - 5'd10;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[i*4 +: 4] = s[3:0];
    end
    r[12] = c;
    return r;
  endfunction

  // Caller guarantees a >= b, so the final borrow is always zero.
  function automatic logic [11:0] bcd_sub(input logic [11:0] a, input logic [11:0] b);
    logic [11:0] r;
    logic [4:0]  an, bn;
    logic        br;
    r  = '0;
    br = 1'b0;
    for (int i = 0; i < 3; i++) begin
      an = {1'b0, a[i*4 +: 4]};
      bn = {1'b0, b[i*4 +: 4]} + {4'd0, br};
      if (an < bn) begin
        r[i*4 +: 4] = 4'(an + 5'd10 - bn);
        br = 1'b1;
      end else begin
        r[i*4 +: 4] = 4'(an - bn);
        br = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic [11:0] clamp_bcd(input logic [11:0] x);
    logic [11:0] r;
    for (int i = 0; i < 3; i++) begin
      r[i*4 +: 4] = (x[i*4 +: 4] > 4'd9) ? 4'd9 : x[i*4 +: 4];
    end
    return r;
  endfunction

  logic [3:0]  dig_cur, dig_up, dig_dn;
  logic [11:0] dbt_amt;
  logic [12:0] add_sum;
  logic        add_ovf;
  logic        any_btn;

  always_comb begin
    case (sel_q)
      2'd1:    dig_cur = amt_q[7:4];
      2'd2:    dig_cur = amt_q[11:8];
      default: dig_cur = amt_q[3:0];
    endcase
    dig_up = (dig_cur == 4'd9) ? 4'd0 : dig_cur + 4'd1;
    dig_dn = (dig_cur == 4'd0) ? 4'd9 : dig_cur - 4'd1;
  end

`ifdef RECHARGE_BONUS_EN
  logic [12:0] bonus_sum;
  always_comb begin
    bonus_sum = bcd_add(bcd_add(bal_q, amt_q)[11:0], 12'h010);
    if (amt_q >= 12'h100) begin
      add_sum = bonus_sum;
      add_ovf = bcd_add(bal_q, amt_q)[12] | bonus_sum[12];
    end else begin
      add_sum = bcd_add(bal_q, amt_q);
      add_ovf = add_sum[12];
    end
  end
`else
  always_comb begin
    add_sum = bcd_add(bal_q, amt_q);
    add_ovf = add_sum[12];
  end
`endif

  assign dbt_amt = clamp_bcd(bus.debit_amt);
  assign any_btn = m_pos | u_pos | d_pos;

  always_comb begin
    state_d     = state_q;
    bal_d       = bal_q;
    amt_d       = amt_q;
    sel_d       = sel_q;
    timer_d     = timer_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    req_seen_d  = req_seen_q;
    short_d     = short_q;
    ack_d       = 1'b0;
    sat_d       = 1'b0;

    if (on) begin
      if (!bus.debit_req) req_seen_d = 1'b0;

      case (state_q)
        IDLE: begin
          if (bus.debit_req && !req_seen_q) begin
            state_d = DEBIT;
          end else if (m_pos) begin
            state_d     = EDIT;
            amt_d       = '0;
            sel_d       = 2'd0;
            timer_d     = '0;
            blink_cnt_d = '0;
            blink_d     = 1'b0;
          end
        end

        EDIT: begin
          if (blink_cnt_q == BW'(HALF_SEC - 1)) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
          end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
          end

          if (any_btn) begin
            timer_d = '0;
            if (u_pos != d_pos) begin
              case (sel_q)
                2'd1:    amt_d[7:4]  = u_pos ? dig_up : dig_dn;
                2'd2:    amt_d[11:8] = u_pos ? dig_up : dig_dn;
                default: amt_d[3:0]  = u_pos ? dig_up : dig_dn;
              endcase
            end
            if (m_pos) begin
              if (sel_q == 2'd2) state_d = COMMIT;
              else               sel_d   = sel_q + 2'd1;
            end
          end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d = IDLE;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end

        COMMIT: begin
          if (add_ovf) begin
            bal_d = 12'h999;
            sat_d = 1'b1;
          end else begin
            bal_d = add_sum[11:0];
          end
          state_d = IDLE;
        end

        DEBIT: begin
          // Valid BCD orders the same as binary, so a plain compare is a decimal compare.
          if (bal_q >= dbt_amt) begin
            bal_d   = bcd_sub(bal_q, dbt_amt);
            short_d = 1'b0;
          end else begin
            bal_d   = 12'h000;
            short_d = 1'b1;
          end
          ack_d      = 1'b1;
          req_seen_d = 1'b1;
          state_d    = IDLE;
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bal_q       <= INIT_BAL;
      amt_q       <= '0;
      sel_q       <= 2'd0;
      timer_q     <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      req_seen_q  <= 1'b0;
      ack_q       <= 1'b0;
      short_q     <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bal_q       <= bal_d;
      amt_q       <= amt_d;
      sel_q       <= sel_d;
      timer_q     <= timer_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      req_seen_q  <= req_seen_d;
      ack_q       <= ack_d;
      short_q     <= short_d;
      sat_q       <= sat_d;
    end
  end

  logic [11:0] amt_shown;

  always_comb begin
    amt_shown = amt_q;
    if (blink_q) begin
      case (sel_q)
        2'd1:    amt_shown[7:4]  = BLANK;
        2'd2:    amt_shown[11:8] = BLANK;
        default: amt_shown[3:0]  = BLANK;
      endcase
    end
    disp = (state_q == EDIT) ? {BLANK, amt_shown} : {BLANK, bal_q};
  end

  assign bus.bal         = bal_q;
  assign bus.debit_ack   = ack_q & on;
  assign bus.debit_short = short_q;
  assign sat             = sat_q & on;
  assign editing         = (state_q == EDIT);

endmodule

// File: tb/tb_wallet_recharge.sv
// Bench for wallet_recharge: directed table, multi-cycle corner sequences, then random ops vs a decimal model.
module tb_wallet_recharge;
  localparam int unsigned TO = 40;
  localparam int unsigned HS = 8;
`ifdef RECHARGE_BONUS_EN
  localparam bit BONUS = 1'b1;
`else
  localparam bit BONUS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, on, m_pos, u_pos, d_pos;
  logic        sat, editing;
  logic [15:0] disp;

  wallet_recharge_if bus_if();

  wallet_recharge #(.INIT_BAL(12'h196), .TIMEOUT_CYC(TO), .HALF_SEC(HS)) dut (
    .clk(clk), .rst(rst), .on(on), .m_pos(m_pos), .u_pos(u_pos), .d_pos(d_pos),
    .bus(bus_if), .sat(sat), .editing(editing), .disp(disp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_bal;

  typedef struct {
    bit          is_debit;
    logic [11:0] val;
    logic [11:0] exp_bal;
    bit          exp_flag;
  } vec_t;
  vec_t tbl[9];

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int from_bcd_clamp(input logic [11:0] x);
    int r = 0;
    int n;
    for (int i = 2; i >= 0; i--) begin
      n = int'(x[i*4 +: 4]);
      if (n > 9) n = 9;
      r = r * 10 + n;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int which);
    if (which == 0) m_pos = 1'b1;
    else if (which == 1) u_pos = 1'b1;
    else d_pos = 1'b1;
    tick();
    m_pos = 1'b0;
    u_pos = 1'b0;
    d_pos = 1'b0;
  endtask

  // Enters EDIT, keys each digit (down-presses for 6..9 to exercise wrap), ends in COMMIT.
  task automatic key_amt(input logic [11:0] a);
    int dig;
    press(0);
    for (int i = 0; i < 3; i++) begin
      dig = int'(a[i*4 +: 4]);
      if (dig <= 5) repeat (dig) press(1);
      else repeat (10 - dig) press(2);
      press(0);
    end
  endtask

  task automatic run_topup(input logic [11:0] a, input logic [11:0] eb, input bit es);
    key_amt(a);
    tick();
    chk("topup_bal", {4'h0, bus_if.bal}, {4'h0, eb});
    chk("topup_sat", {15'h0, sat}, {15'h0, es});
    chk("topup_editing", {15'h0, editing}, 16'h0);
    tick();
    chk("sat_one_cycle", {15'h0, sat}, 16'h0);
  endtask

  task automatic run_debit(input logic [11:0] a, input logic [11:0] eb, input bit es, input int hold);
    int n = 0;
    bus_if.debit_amt = a;
    bus_if.debit_req = 1'b1;
    tick();
    chk("ack_early", {15'h0, bus_if.debit_ack}, 16'h0);
    tick();
    chk("ack", {15'h0, bus_if.debit_ack}, 16'h1);
    chk("debit_bal", {4'h0, bus_if.bal}, {4'h0, eb});
    chk("debit_short", {15'h0, bus_if.debit_short}, {15'h0, es});
    for (int i = 0; i < hold; i++) begin
      tick();
      if (bus_if.debit_ack) n++;
    end
    chk("dup_ack", 16'(n), 16'h0);
    bus_if.debit_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_ack(input int max, output bit got);
    got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      tick();
      if (bus_if.debit_ack) got = 1'b1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    bit got;
    int a, d, e, n;
    bit s;
    logic [11:0] raw;

    tbl[0] = '{1'b0, 12'h025, 12'h221, 1'b0};
    tbl[1] = '{1'b1, 12'h045, 12'h176, 1'b0};
    tbl[2] = '{1'b1, 12'h300, 12'h000, 1'b1};
    tbl[3] = '{1'b0, 12'h176, BONUS ? 12'h186 : 12'h176, 1'b0};
    tbl[4] = '{1'b0, 12'h900, 12'h999, 1'b1};
    tbl[5] = '{1'b1, 12'h0AF, 12'h900, 1'b0};
    tbl[6] = '{1'b0, 12'h099, 12'h999, 1'b0};
    tbl[7] = '{1'b1, 12'h999, 12'h000, 1'b0};
    tbl[8] = '{1'b0, 12'h100, BONUS ? 12'h110 : 12'h100, 1'b0};

    rst = 1'b0; on = 1'b1; m_pos = 1'b0; u_pos = 1'b0; d_pos = 1'b0;
    bus_if.debit_req = 1'b0; bus_if.debit_amt = 12'h000;
    tick(); tick();
    chk("rst_bal", {4'h0, bus_if.bal}, 16'h0196);
    chk("rst_disp", disp, 16'hB196);
    chk("rst_ack", {15'h0, bus_if.debit_ack}, 16'h0);
    chk("rst_editing", {15'h0, editing}, 16'h0);
    chk("rst_short", {15'h0, bus_if.debit_short}, 16'h0);
    chk("rst_sat", {15'h0, sat}, 16'h0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].is_debit) run_debit(tbl[i].val, tbl[i].exp_bal, tbl[i].exp_flag, 20);
      else run_topup(tbl[i].val, tbl[i].exp_bal, tbl[i].exp_flag);
      chk("idle_disp", disp, {4'hB, tbl[i].exp_bal});
    end
    m_bal = from_bcd_clamp(tbl[8].exp_bal);

    // Edit, digit wrap, blink, exact timeout boundary.
    press(0);
    chk("edit_enter", {15'h0, editing}, 16'h1);
    chk("edit_disp0", disp, 16'hB000);
    press(2);
    chk("ones_wrap_down", disp, 16'hB009);
    press(2); press(2);
    chk("ones_seven", disp, 16'hB007);
    repeat (5) tick();
    chk("blink_on", disp, 16'hB00B);
    repeat (TO - 6) tick();
    chk("pre_timeout", {15'h0, editing}, 16'h1);
    tick();
    chk("timeout_idle", {15'h0, editing}, 16'h0);
    chk("timeout_bal", {4'h0, bus_if.bal}, {4'h0, to_bcd(m_bal)});

    // Debit raised mid-edit is held off until IDLE.
    press(0);
    bus_if.debit_amt = 12'h010;
    bus_if.debit_req = 1'b1;
    n = 0;
    repeat (10) begin
      tick();
      if (bus_if.debit_ack) n++;
    end
    chk("no_ack_in_edit", 16'(n), 16'h0);
    chk("still_editing", {15'h0, editing}, 16'h1);
    press(1); press(0); press(0); press(0);
    wait_ack(10, got);
    chk("pending_ack", {15'h0, got}, 16'h1);
    m_bal = m_bal + 1 - 10;
    chk("pending_bal", {4'h0, bus_if.bal}, {4'h0, to_bcd(m_bal)});
    bus_if.debit_req = 1'b0;
    tick(); tick();

    // on low freezes the editor.
    press(0);
    on = 1'b0;
    repeat (3) press(1);
    repeat (20) tick();
    chk("frozen_edit", disp, 16'hB000);
    on = 1'b1;
    press(1);
    chk("resume_edit", disp, 16'hB001);
    repeat (TO) tick();
    chk("freeze_timeout", {15'h0, editing}, 16'h0);

    // sat is masked by on and not replayed when on returns.
    key_amt(12'h999);
    tick();
    chk("sat_full", {15'h0, sat}, 16'h1);
    chk("sat_bal", {4'h0, bus_if.bal}, 16'h0999);
    on = 1'b0;
    #1;
    chk("sat_masked", {15'h0, sat}, 16'h0);
    tick();
    on = 1'b1;
    #1;
    chk("sat_no_replay", {15'h0, sat}, 16'h0);
    m_bal = 999;

    // Debit request ignored while off, served once on returns.
    on = 1'b0;
    bus_if.debit_amt = 12'h001;
    bus_if.debit_req = 1'b1;
    n = 0;
    repeat (5) begin
      tick();
      if (bus_if.debit_ack) n++;
    end
    chk("off_no_ack", 16'(n), 16'h0);
    chk("off_bal", {4'h0, bus_if.bal}, 16'h0999);
    on = 1'b1;
    tick(); tick();
    chk("on_ack", {15'h0, bus_if.debit_ack}, 16'h1);
    chk("on_bal", {4'h0, bus_if.bal}, 16'h0998);
    bus_if.debit_req = 1'b0;
    tick(); tick();

    // Reset mid-edit abandons everything.
    press(0); press(1);
    rst = 1'b0;
    #1;
    chk("mid_rst_bal", {4'h0, bus_if.bal}, 16'h0196);
    chk("mid_rst_editing", {15'h0, editing}, 16'h0);
    chk("mid_rst_disp", disp, 16'hB196);
    tick();
    rst = 1'b1;
    tick();
    m_bal = 196;

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        a = int'($urandom_range(0, 999));
        e = m_bal + a + ((BONUS && a >= 100) ? 10 : 0);
        s = (e > 999);
        if (s) e = 999;
        run_topup(to_bcd(a), to_bcd(e), s);
      end else begin
        if ($urandom_range(0, 3) == 0) raw = 12'($urandom_range(0, 4095));
        else raw = to_bcd(int'($urandom_range(0, 999)));
        d = from_bcd_clamp(raw);
        s = (m_bal < d);
        e = s ? 0 : m_bal - d;
        run_debit(raw, to_bcd(e), s, int'($urandom_range(0, 3)));
      end
      m_bal = e;
      chk("rand_disp", disp, {4'hB, to_bcd(m_bal)});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
